// File: rtl/div10x4.sv
// Radix-2 restoring divider: 10-bit dividend / 4-bit divisor, one quotient bit per clock.
// Valid/ready handshake on both the input and the output side.
module div10x4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [9:0] a,
   input  logic [3:0] b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [9:0] q,
   output logic [3:0] r,
   output logic       ovf,
   output logic       dz
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [9:0]  a_shift_q, a_shift_d;
   logic [3:0]  b_q, b_d;
   logic [4:0]  rem_q, rem_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [9:0]  q_work_q, q_work_d;
   logic [9:0]  q_q, q_d;
   logic [3:0]  r_q, r_d;
   logic        ovf_q, ovf_d;
   logic        dz_q, dz_d;

   logic [4:0]  p;
   logic        q_bit;
   logic [4:0]  rem_step;
   logic [9:0]  q_work_step;

   // One restoring step; rem stays below b, so rem[4] is always zero.
   always_comb begin
      p           = {rem_q[3:0], a_shift_q[9]};
      q_bit       = (p >= {1'b0, b_q});
      rem_step    = q_bit ? (p - {1'b0, b_q}) : p;
      q_work_step = {q_work_q[8:0], q_bit};
   end

   always_comb begin
      state_d   = state_q;
      a_shift_d = a_shift_q;
      b_d       = b_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      q_work_d  = q_work_q;
      q_d       = q_q;
      r_d       = r_q;
      ovf_d     = ovf_q;
      dz_d      = dz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               b_d = b;
               if (b == 4'd0) begin
                  q_d     = 10'h3FF;
                  r_d     = 4'd0;
                  ovf_d   = 1'b1;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  a_shift_d = a;
                  rem_d     = 5'd0;
                  cnt_d     = 4'd9;
                  q_work_d  = 10'd0;
                  state_d   = BUSY;
               end
            end
         end
         BUSY: begin
            rem_d     = rem_step;
            q_work_d  = q_work_step;
            a_shift_d = {a_shift_q[8:0], 1'b0};
            if (cnt_q == 4'd0) begin
               q_d     = q_work_step;
               r_d     = rem_step[3:0];
               ovf_d   = |q_work_step[9:6];
               dz_d    = 1'b0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_shift_q <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         q_work_q  <= '0;
         q_q       <= '0;
         r_q       <= '0;
         ovf_q     <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_shift_q <= a_shift_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         q_work_q  <= q_work_d;
         q_q       <= q_d;
         r_q       <= r_d;
         ovf_q     <= ovf_d;
         dz_q      <= dz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign q         = q_q;
   assign r         = r_q;
   assign ovf       = ovf_q;
   assign dz        = dz_q;

endmodule
